unidade_controlo: RTL and testbench

Fetch/decode/execute sequencer for the 8-bit instruction ROM (5-bit `endereco`, 8-bit `dado`). Holds the program counter, latches each instruction from the combinational ROM, decodes it and issues one-cycle control strobes to the register/ALU datapath. Handles jumps, conditional skip, a one-level call/return and halt, with a datapath stall input.

---
 rtl/unidade_controlo.sv | 125 ++++++++++++
 tb/tb_unidade_controlo.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/unidade_controlo.sv
// Fetch/decode/execute sequencer for an 8-bit instruction ROM with 5-bit PC,
// one-level call/return, conditional skip, halt and datapath stall.
module unidade_controlo (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       espera,
    input  logic [7:0] flags,
    input  logic [7:0] dado,
    output logic [4:0] endereco,
    output logic [2:0] reg_sel,
    output logic [1:0] alu_fn,
    output logic       alu_en,
    output logic       ld_en,
    output logic       st_en,
    output logic       parado
);
    localparam int unsigned PC_W = 5;
    localparam int unsigned IR_W = 8;

    localparam logic [2:0] OP_ALU   = 3'b000;
    localparam logic [2:0] OP_SKIP  = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_HALT  = 3'b100;
    localparam logic [2:0] OP_JMP   = 3'b101;
    localparam logic [2:0] OP_CALL  = 3'b110;
    localparam logic [2:0] OP_RET   = 3'b111;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [PC_W-1:0] r_pc, w_pc_nxt;
    logic [PC_W-1:0] r_ret, w_ret_nxt;
    logic [IR_W-1:0] r_ir, w_ir_nxt;
    logic            r_alu_en, r_ld_en, r_st_en, r_parado;
    logic            w_alu_en_nxt, w_ld_en_nxt, w_st_en_nxt, w_parado_nxt;
    logic [2:0]      w_op;
    logic [PC_W-1:0] w_pc_inc;
    logic            w_exec_nxt;

    assign w_op     = r_ir[7:5];
    assign w_pc_inc = r_pc + PC_W'(1);

    // Next-state, PC/ret/ir update and decode of the registered strobes.
    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_ret_nxt   = r_ret;
        w_ir_nxt    = r_ir;
        case (r_state)
            S_FETCH: begin
                if (run) begin
                    w_ir_nxt    = dado;
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC: begin
                if (!espera) begin
                    w_state_nxt = S_FETCH;
                    case (w_op)
                        OP_SKIP:  w_pc_nxt = flags[r_ir[4:2]] ? (r_pc + PC_W'(2)) : w_pc_inc;
                        OP_HALT: begin
                            w_pc_nxt    = w_pc_inc;
                            w_state_nxt = S_HALT;
                        end
                        OP_JMP:   w_pc_nxt = r_ir[4:0];
                        OP_CALL: begin
                            w_ret_nxt = w_pc_inc;
                            w_pc_nxt  = r_ir[4:0];
                        end
                        OP_RET:   w_pc_nxt = r_ret;
                        default:  w_pc_nxt = w_pc_inc;
                    endcase
                end
            end
            S_HALT: begin
                if (run) w_state_nxt = S_FETCH;
            end
            default: w_state_nxt = S_FETCH;
        endcase

        w_exec_nxt   = (w_state_nxt == S_EXEC);
        w_alu_en_nxt = w_exec_nxt && (w_ir_nxt[7:5] == OP_ALU);
        w_ld_en_nxt  = w_exec_nxt && (w_ir_nxt[7:5] == OP_LOAD);
        w_st_en_nxt  = w_exec_nxt && (w_ir_nxt[7:5] == OP_STORE);
        w_parado_nxt = (w_state_nxt == S_HALT);
    end

    // Reset abandons any in-flight instruction, including a stalled EXEC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_FETCH;
            r_pc     <= '0;
            r_ret    <= '0;
            r_ir     <= '0;
            r_alu_en <= 1'b0;
            r_ld_en  <= 1'b0;
            r_st_en  <= 1'b0;
            r_parado <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pc     <= w_pc_nxt;
            r_ret    <= w_ret_nxt;
            r_ir     <= w_ir_nxt;
            r_alu_en <= w_alu_en_nxt;
            r_ld_en  <= w_ld_en_nxt;
            r_st_en  <= w_st_en_nxt;
            r_parado <= w_parado_nxt;
        end
    end

    assign endereco = r_pc;
    assign reg_sel  = r_ir[4:2];
    assign alu_fn   = r_ir[1:0];
    assign alu_en   = r_alu_en;
    assign ld_en    = r_ld_en;
    assign st_en    = r_st_en;
    assign parado   = r_parado;

endmodule

// File: tb/tb_unidade_controlo.sv
// Scoreboard bench for unidade_controlo: instruction-level reference model feeds
// an expectation queue; a monitor compares DUT outputs after every clock edge.
module tb_unidade_controlo;

    typedef struct packed {
        logic [4:0] ende;
        logic [2:0] rs;
        logic [1:0] fn;
        logic       alu;
        logic       ld;
        logic       st;
        logic       par;
    } exp_t;

    localparam int PH_FETCH = 0;
    localparam int PH_EXEC  = 1;
    localparam int PH_HALT  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       run = 1'b0;
    logic       espera = 1'b0;
    logic [7:0] flags = '0;
    logic [7:0] dado;
    logic [4:0] endereco;
    logic [2:0] reg_sel;
    logic [1:0] alu_fn;
    logic       alu_en, ld_en, st_en, parado;

    logic [7:0] rom [32];
    exp_t       exp_q [$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Instruction-level model state
    int         m_pc = 0;
    int         m_ret = 0;
    logic [7:0] m_ir = '0;
    int         m_phase = PH_FETCH;

    unidade_controlo dut (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .espera   (espera),
        .flags    (flags),
        .dado     (dado),
        .endereco (endereco),
        .reg_sel  (reg_sel),
        .alu_fn   (alu_fn),
        .alu_en   (alu_en),
        .ld_en    (ld_en),
        .st_en    (st_en),
        .parado   (parado)
    );

    assign dado = rom[endereco];

    always #5 clk = ~clk;

    // Execute the instruction held in m_ir at address m_pc.
    task automatic execute();
        int op;
        int addr;
        op   = int'(m_ir[7:5]);
        addr = int'(m_ir[4:0]);
        m_phase = PH_FETCH;
        case (op)
            1: m_pc = (m_pc + (flags[m_ir[4:2]] ? 2 : 1)) % 32;
            4: begin m_pc = (m_pc + 1) % 32; m_phase = PH_HALT; end
            5: m_pc = addr;
            6: begin m_ret = (m_pc + 1) % 32; m_pc = addr; end
            7: m_pc = m_ret;
            default: m_pc = (m_pc + 1) % 32;
        endcase
    endtask

    // Apply inputs for the next edge, advance the model, queue the expectation.
    task automatic drive(input logic i_rst, input logic i_run, input logic i_esp,
                         input logic [7:0] i_flags);
        exp_t e;
        int   op;
        @(negedge clk);
        rst = i_rst; run = i_run; espera = i_esp; flags = i_flags;
        cyc++;
        if (i_rst) begin
            m_pc = 0; m_ret = 0; m_ir = '0; m_phase = PH_FETCH;
        end else if (m_phase == PH_FETCH) begin
            if (i_run) begin m_ir = rom[m_pc]; m_phase = PH_EXEC; end
        end else if (m_phase == PH_EXEC) begin
            if (!i_esp) execute();
        end else begin
            if (i_run) m_phase = PH_FETCH;
        end
        op    = int'(m_ir[7:5]);
        e.ende = 5'(m_pc);
        e.rs   = m_ir[4:2];
        e.fn   = m_ir[1:0];
        e.alu  = (m_phase == PH_EXEC) && (op == 0);
        e.ld   = (m_phase == PH_EXEC) && (op == 2);
        e.st   = (m_phase == PH_EXEC) && (op == 3);
        e.par  = (m_phase == PH_HALT);
        exp_q.push_back(e);
    endtask

    // Monitor: one comparison per clock edge for which an expectation exists.
    initial begin
        exp_t e;
        exp_t g;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                g = '{endereco, reg_sel, alu_fn, alu_en, ld_en, st_en, parado};
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got end=%0d rs=%0d fn=%0d alu=%b ld=%b st=%b par=%b want end=%0d rs=%0d fn=%0d alu=%b ld=%b st=%b par=%b",
                             $time, g.ende, g.rs, g.fn, g.alu, g.ld, g.st, g.par,
                             e.ende, e.rs, e.fn, e.alu, e.ld, e.st, e.par);
                end
            end
        end
    end

    initial begin
        int wait_cyc;
        for (int i = 0; i < 32; i++) rom[i] = 8'h00;
        rom[0]  = 8'b010_100_00;
        rom[1]  = 8'b000_111_10;
        rom[2]  = 8'b110_01001;
        rom[9]  = 8'b001_101_00;
        rom[10] = 8'b111_00000;
        rom[11] = 8'b111_00000;
        rom[3]  = 8'b100_00000;
        rom[4]  = 8'b101_11111;
        rom[31] = 8'b000_000_01;

        // Directed program: linear, call, skip both ways, ret, halt/resume, wrap
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 240; c++) begin
            drive(1'b0,
                  !((c % 37) >= 30 && (c % 37) <= 33),
                  ((c % 13) >= 9 && (c % 13) <= 11),
                  ((c / 40) % 2 == 1) ? 8'h20 : 8'h00);
        end

        // Reset while stalled in EXEC
        for (int c = 0; c < 4; c++) drive(1'b0, 1'b1, 1'b1, 8'h00);
        drive(1'b1, 1'b1, 1'b1, 8'h00);

        // RET straight after reset returns to address 0
        rom[0] = 8'b111_00000;
        drive(1'b1, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 10; c++) drive(1'b0, 1'b1, 1'b0, 8'h00);

        // Random programs with random run/espera/flags and occasional reset
        for (int ep = 0; ep < 8; ep++) begin
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            for (int i = 0; i < 32; i++) rom[i] = 8'($urandom);
            drive(1'b1, 1'b0, 1'b0, 8'h00);
            for (int c = 0; c < 400; c++) begin
                drive($urandom_range(0, 199) == 0,
                      $urandom_range(0, 3) != 0,
                      $urandom_range(0, 3) == 0,
                      8'($urandom));
            end
        end

        wait_cyc = 0;
        while (exp_q.size() > 0 && wait_cyc < 10) begin
            @(posedge clk);
            wait_cyc++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
